seven_seg_scan: RTL and testbench

Multiplexed N-digit 7-segment display driver. It is the clocked successor of the single-digit decoder with lamp test and ripple blanking. It holds a tear-free shadow copy of a packed hex/BCD value and scans one digit per refresh slot. Each slot has an anti-ghost blanking gap, multi-digit leading-zero suppression, an active-low lamp test and a decimal point per digit. It sits between the datapath and the board's shared segment bus and digit-enable pins.

---
 rtl/seven_seg_scan.sv | 165 ++++++++++++++++
 tb/tb_seven_seg_scan.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit 7-segment scanner with tear-free shadow register,
// anti-ghost blanking gap, leading-zero suppression, lamp test and per-digit dp.
module seven_seg_scan #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 1,
    parameter bit          HEX_EN         = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lamp_n,
    input  logic                  rbi_n,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     stage_q, stage_d, shadow_q, shadow_d;
    logic [DIGITS-1:0] stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic              pend_q, pend_d;
    logic              wrap_q, wrap_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic              fd_q, fd_d;

    logic              slot_end_c, frame_end_c;
    logic [3:0]        nib_c;
    logic              cur_dp_c, cur_blank_c, zero_run_c;
    logic [DIGITS-1:0] blank_c;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] d;
        case (n)
            4'h0: d = 7'h7E;
            4'h1: d = 7'h0C;
            4'h2: d = 7'h37;
            4'h3: d = 7'h1F;
            4'h4: d = 7'h4D;
            4'h5: d = 7'h5B;
            4'h6: d = 7'h7B;
            4'h7: d = 7'h0E;
            4'h8: d = 7'h7F;
            4'h9: d = 7'h5F;
            4'hA: d = 7'h6F;
            4'hB: d = 7'h79;
            4'hC: d = 7'h72;
            4'hD: d = 7'h3D;
            4'hE: d = 7'h73;
            default: d = 7'h63;
        endcase
        if (!HEX_EN && (n > 4'd9)) d = 7'h00;
        return d;
    endfunction

    // Slot/digit counters and the staging -> shadow handoff at the frame boundary
    always_comb begin
        slot_end_c  = (presc_q == PW'(REFRESH_DIV - 1));
        frame_end_c = slot_end_c && (idx_q == IW'(DIGITS - 1));
        presc_d     = slot_end_c ? '0 : presc_q + PW'(1);
        idx_d       = idx_q;
        if (slot_end_c) idx_d = frame_end_c ? '0 : idx_q + IW'(1);

        stage_d     = stage_q;
        stage_dp_d  = stage_dp_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        if (frame_end_c && pend_q) begin
            shadow_d    = stage_q;
            shadow_dp_d = stage_dp_q;
            pend_d      = 1'b0;
        end
        // A load on the boundary cycle lands in staging for the following frame
        if (load) begin
            stage_d    = value;
            stage_dp_d = dp_in;
            pend_d     = 1'b1;
        end

        wrap_d = frame_end_c;
        fd_d   = wrap_q;
    end

    // Digit decode with leading-zero suppression and lamp override
    always_comb begin
        zero_run_c = 1'b1;
        blank_c    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run_c = zero_run_c && (shadow_q[4*k +: 4] == 4'h0) && !shadow_dp_q[k];
            blank_c[k] = (k != 0) && zero_run_c && !rbi_n;
        end

        nib_c       = '0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib_c       = shadow_q[4*k +: 4];
                cur_dp_c    = shadow_dp_q[k];
                cur_blank_c = blank_c[k];
            end
        end

        seg_d = cur_blank_c ? 7'h00 : decode(nib_c);
        dp_d  = cur_dp_c;
        if (!lamp_n) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end

        dig_d = '0;
        if (presc_q >= PW'(BLANK_CYCLES)) begin
            for (int k = 0; k < DIGITS; k++) dig_d[k] = (idx_q == IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q     <= '0;
            idx_q       <= '0;
            stage_q     <= '0;
            stage_dp_q  <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= 1'b0;
            wrap_q      <= 1'b0;
            seg_q       <= '0;
            dp_q        <= 1'b0;
            dig_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            stage_q     <= stage_d;
            stage_dp_q  <= stage_dp_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_q      <= pend_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
            fd_q        <= fd_d;
        end
    end

    assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = SEG_ACTIVE_LOW ? ~dp_q  : dp_q;
    assign dig_sel    = DIG_ACTIVE_LOW ? ~dig_q : dig_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: two instances (hex/active-high and no-hex/active-low
// pins) checked every cycle against an arithmetic model, plus literal spot checks.
module tb_seven_seg_scan;

    localparam int R = 4;
    localparam int D = 4;
    localparam int B = 1;
    localparam int F = R * D;

    logic        clk, rst_n, load, lamp_n, rbi_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg_h, seg_n;
    logic        dp_h, dp_n, fd_h, fd_n;
    logic [3:0]  dig_h, dig_n;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b1),
                     .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_hex (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .lamp_n(lamp_n), .rbi_n(rbi_n), .seg(seg_h), .dp(dp_h), .dig_sel(dig_h),
        .frame_done(fd_h));

    seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYCLES(B), .HEX_EN(1'b0),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_nohex (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .lamp_n(lamp_n), .rbi_n(rbi_n), .seg(seg_n), .dp(dp_n), .dig_sel(dig_n),
        .frame_done(fd_n));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Model: m_cnt = clock edges since reset release; everything follows from it.
    logic [6:0]  dec_tab [16] = '{7'h7E, 7'h0C, 7'h37, 7'h1F, 7'h4D, 7'h5B, 7'h7B, 7'h0E,
                                  7'h7F, 7'h5F, 7'h6F, 7'h79, 7'h72, 7'h3D, 7'h73, 7'h63};
    int          m_cnt = 0;
    logic [15:0] m_shadow = '0, m_stage = '0;
    logic [3:0]  m_sdp = '0, m_stage_dp = '0;
    logic        m_pend = 1'b0;
    logic [6:0]  e_seg_h = '0, e_seg_n = '0;
    logic        e_dp = 1'b0, e_fd = 1'b0;
    logic [3:0]  e_dig = '0;

    function automatic logic [6:0] exp_seg(input logic [15:0] sh, input logic [3:0] sdp,
                                           input int k, input logic lmp_n, input logic rb_n,
                                           input bit hex);
        int nib;
        nib = int'((sh >> (4 * k)) & 16'h000F);
        if (!lmp_n) return 7'h7F;
        if (!rb_n && k > 0 && (sh >> (4 * k)) == 16'h0 && (sdp >> k) == 4'h0) return 7'h00;
        if (!hex && nib > 9) return 7'h00;
        return dec_tab[nib];
    endfunction

    always @(posedge clk) begin : model
        int presc, idx;
        bit wrap;
        if (!rst_n) begin
            m_cnt   <= 0;
            m_shadow <= '0;
            m_sdp   <= '0;
            m_pend  <= 1'b0;
            e_seg_h <= '0;
            e_seg_n <= '0;
            e_dp    <= 1'b0;
            e_dig   <= '0;
            e_fd    <= 1'b0;
        end else begin
            presc = m_cnt % R;
            idx   = (m_cnt / R) % D;
            wrap  = (presc == R - 1) && (idx == D - 1);
            e_dig   <= (presc < B) ? 4'b0000 : 4'(1 << idx);
            e_seg_h <= exp_seg(m_shadow, m_sdp, idx, lamp_n, rbi_n, 1'b1);
            e_seg_n <= exp_seg(m_shadow, m_sdp, idx, lamp_n, rbi_n, 1'b0);
            e_dp    <= !lamp_n ? 1'b1 : m_sdp[idx];
            e_fd    <= (m_cnt > 0) && (m_cnt % F == 0);
            if (wrap && m_pend) begin
                m_shadow <= m_stage;
                m_sdp    <= m_stage_dp;
            end
            if (load) begin
                m_stage    <= value;
                m_stage_dp <= dp_in;
                m_pend     <= 1'b1;
            end else if (wrap) begin
                m_pend <= 1'b0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model cnt %0d)", name, got, exp, m_cnt);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [6:0] ns;
        logic [3:0] nd;
        logic       np;
        if (chk_en) begin
            ns = ~e_seg_n;
            nd = ~e_dig;
            np = ~e_dp;
            chk("hex_seg", seg_h, e_seg_h);
            chk("hex_dp", dp_h, e_dp);
            chk("hex_dig", dig_h, e_dig);
            chk("hex_fd", fd_h, e_fd);
            chk("nohex_seg_pin", seg_n, ns);
            chk("nohex_dp_pin", dp_n, np);
            chk("nohex_dig_pin", dig_n, nd);
            chk("nohex_fd", fd_n, e_fd);
        end
    end

    // Advance to the negedge whose outputs reflect internal counter state s
    task automatic at_state(input int s);
        int g;
        g = 0;
        while (m_cnt != s + 1 && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (m_cnt != s + 1) begin
            n_tests++;
            n_fail++;
            $display("FAIL at_state: cnt %0d never reached %0d", m_cnt, s + 1);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 16'hFFFF;
        dp_in = 4'hF;
    endtask

    initial begin
        logic [15:0] v;
        int          g;
        rst_n  = 1'b0;
        load   = 1'b0;
        value  = '0;
        dp_in  = '0;
        lamp_n = 1'b1;
        rbi_n  = 1'b1;
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_seg", seg_h, 7'h00);
        chk("rst_dig", dig_h, 4'h0);
        chk("rst_fd", fd_h, 1'b0);
        chk("rst_seg_pin_inv", seg_n, 7'h7F);
        rst_n = 1'b1;

        // Scan timing and frame pulse
        at_state(0);  chk("gap_dig0", dig_h, 4'b0000);
        at_state(1);  chk("dig0_on", dig_h, 4'b0001);
        chk("dig0_seg_zero", seg_h, 7'h7E);
        at_state(4);  chk("gap_dig1", dig_h, 4'b0000);
        at_state(5);  chk("dig1_on", dig_h, 4'b0010);
        at_state(15); chk("fd_before", fd_h, 1'b0);
        at_state(16); chk("fd_pulse", fd_h, 1'b1);
        at_state(17); chk("fd_after", fd_h, 1'b0);

        // Mid-frame load waits for the next frame
        do_load(16'h1234, 4'h0);
        at_state(29); chk("old_shadow_d3", seg_h, 7'h7E);
        at_state(33); chk("1234_d0", seg_h, 7'h4D);
        chk("1234_d0_dig", dig_h, 4'b0001);
        at_state(37); chk("1234_d1", seg_h, 7'h1F);
        at_state(41); chk("1234_d2", seg_h, 7'h37);
        at_state(45); chk("1234_d3", seg_h, 7'h0C);

        // Leading-zero blanking and dp interaction
        rbi_n = 1'b0;
        do_load(16'h0050, 4'b0000);
        at_state(65); chk("rbi_d0", seg_h, 7'h7E);
        at_state(69); chk("rbi_d1", seg_h, 7'h5B);
        at_state(73); chk("rbi_d2", seg_h, 7'h00);
        at_state(77); chk("rbi_d3", seg_h, 7'h00);
        do_load(16'h0050, 4'b0100);
        at_state(85); chk("rbidp_d1", seg_h, 7'h5B);
        at_state(89); chk("rbidp_d2_seg", seg_h, 7'h7E);
        chk("rbidp_d2_dp", dp_h, 1'b1);
        at_state(93); chk("rbidp_d3", seg_h, 7'h00);

        // Hex letters, and blank letters on the no-hex instance
        rbi_n = 1'b1;
        do_load(16'hABCD, 4'h0);
        at_state(97);  chk("hex_d0", seg_h, 7'h3D);
        chk("nohex_d0_pin", seg_n, 7'h7F);
        at_state(101); chk("hex_d1", seg_h, 7'h72);
        at_state(105); chk("hex_d2", seg_h, 7'h79);
        at_state(109); chk("hex_d3", seg_h, 7'h6F);
        chk("nohex_d3_pin", seg_n, 7'h7F);

        // Lamp test overrides blanking, including the gap cycle
        rbi_n = 1'b0;
        do_load(16'h0000, 4'h0);
        lamp_n = 1'b0;
        at_state(113); chk("lamp_d0_seg", seg_h, 7'h7F);
        chk("lamp_d0_dp", dp_h, 1'b1);
        at_state(116); chk("lamp_gap_seg", seg_h, 7'h7F);
        chk("lamp_gap_dig", dig_h, 4'b0000);
        at_state(121); chk("lamp_d2_seg", seg_h, 7'h7F);
        at_state(125); chk("lamp_d3_seg", seg_h, 7'h7F);
        lamp_n = 1'b1;
        at_state(129); chk("unlamp_d0", seg_h, 7'h7E);
        at_state(133); chk("unlamp_d1", seg_h, 7'h00);

        // Load coinciding with the frame boundary is deferred one frame
        at_state(142);
        do_load(16'h9876, 4'h0);
        at_state(145); chk("coinc_hold_d0", seg_h, 7'h7E);
        at_state(161); chk("coinc_d0", seg_h, 7'h7B);
        at_state(165); chk("coinc_d1", seg_h, 7'h0E);
        at_state(169); chk("coinc_d2", seg_h, 7'h7F);
        at_state(173); chk("coinc_d3", seg_h, 7'h5F);

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 640; i++) begin
            for (int k = 0; k < 4; k++)
                v[4*k +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
            value  = v;
            dp_in  = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
            load   = ($urandom % 6 == 0);
            lamp_n = ($urandom % 16 != 0);
            rbi_n  = 1'($urandom);
            @(negedge clk);
        end
        load   = 1'b0;
        lamp_n = 1'b1;
        rbi_n  = 1'b1;
        dp_in  = '0;
        value  = '0;

        // Reset mid-slot on digit 2 with a load pending
        g = 0;
        while (m_cnt % F != 9 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (m_cnt % F != 9) begin
            n_tests++;
            n_fail++;
            $display("FAIL sync_idx2: cnt %0d", m_cnt);
        end
        do_load(16'h5555, 4'hF);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_seg", seg_h, 7'h00);
        chk("midrst_dp", dp_h, 1'b0);
        chk("midrst_dig", dig_h, 4'h0);
        chk("midrst_dig_pin", dig_n, 4'hF);
        rst_n = 1'b1;
        at_state(33); chk("postrst_d0", seg_h, 7'h7E);
        chk("postrst_d0_dp", dp_h, 1'b0);
        at_state(37); chk("postrst_d1", seg_h, 7'h7E);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
